// File: rtl/riscv16_pkg.sv
// Shared constants for the riscv16 core and its instruction-memory loader.
package riscv16_pkg;
  localparam int INSTR_W     = 16;
  localparam int IMEM_ADDR_W = 4;
  localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;
  localparam int BYTE_W      = 8;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_COUNT,
    LD_HI,
    LD_LO,
    LD_CSUM,
    LD_DONE,
    LD_ERROR
  } ld_state_e;
endpackage

// File: rtl/imem_loader.sv
// Fills instruction memory from a counted, XOR-checksummed byte stream and
// keeps the CPU in reset until a load with a good checksum has completed.
module imem_loader
  import riscv16_pkg::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int INSTR_W = riscv16_pkg::INSTR_W,
  parameter int BYTE_W  = riscv16_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [BYTE_W-1:0] MAX_N = BYTE_W'(2 ** ADDR_W);

  ld_state_e          state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [ADDR_W:0]    words_q, words_d;
  logic [ADDR_W:0]    n_q, n_d;
  logic [BYTE_W-1:0]  acc_q, acc_d;
  logic [BYTE_W-1:0]  hi_q, hi_d;
  logic               xfer;

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    words_d   = words_q;
    n_d       = n_q;
    acc_d     = acc_q;
    hi_d      = hi_q;

    unique case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) begin
          state_d   = LD_COUNT;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          cpu_rst_d = 1'b1;
        end
      end
      LD_COUNT: begin
        if (xfer) begin
          acc_d = in_data;
          if (in_data == '0 || in_data > MAX_N) begin
            state_d = LD_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            n_d     = in_data[ADDR_W:0];
            words_d = '0;
            state_d = LD_HI;
          end
        end
      end
      LD_HI: begin
        if (xfer) begin
          hi_d    = in_data;
          acc_d   = acc_q ^ in_data;
          state_d = LD_LO;
        end
      end
      LD_LO: begin
        // The word write is registered here so the stream never stalls for it.
        if (xfer) begin
          acc_d   = acc_q ^ in_data;
          we_d    = 1'b1;
          addr_d  = words_q[ADDR_W-1:0];
          wdata_d = {hi_q, in_data};
          words_d = words_q + (ADDR_W+1)'(1);
          state_d = (words_d < n_q) ? LD_HI : LD_CSUM;
        end
      end
      LD_CSUM: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (in_data == acc_q) begin
            state_d   = LD_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = LD_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase

    in_ready_d = (state_d == LD_COUNT) || (state_d == LD_HI) ||
                 (state_d == LD_LO)    || (state_d == LD_CSUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LD_IDLE;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      words_q    <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      words_q    <= words_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued by the
// stimulus and retired by a monitor whenever the loader strobes imem_we.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_rst, busy, done, error;
  logic [3:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [4:0]  words_loaded;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%04h, expected no write", imem_addr, imem_wdata);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%04h, expected addr=%0h data=%04h",
                   imem_addr, imem_wdata, e[19:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && t < 50) begin tick(); t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %02h, expected 1", b);
    end
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic chk_drained(input string name);
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic chk_done(input logic [4:0] nw);
    @(negedge clk);
    chk("done", done, 1);
    chk("error_clear", error, 0);
    chk("cpu_rst_released", cpu_rst, 0);
    chk("busy_clear", busy, 0);
    chk("words_loaded", words_loaded, nw);
    chk("in_ready_idle", in_ready, 0);
  endtask

  task automatic stream1(input logic [7:0] csum, input int gap);
    expect_write(4'h0, 16'h1234);
    expect_write(4'h1, 16'hABCD);
    send(8'h02, gap); send(8'h12, gap); send(8'h34, gap);
    send(8'hAB, gap); send(8'hCD, gap); send(csum, gap);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_error", {done, error}, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_we_addr_data", {imem_we, imem_addr, imem_wdata}, 0);
    tick(); rst = 1'b0; tick();

    // Basic two-word load at one byte per cycle.
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_cpu_rst", cpu_rst, 1);
    stream1(8'h42, 0);
    chk_done(5'd2);
    chk_drained("s1_writes");

    // Bad checksum: words are still written, then ERROR.
    pulse_start();
    @(negedge clk);
    chk("restart_clears_done", done, 0);
    chk("restart_cpu_rst", cpu_rst, 1);
    stream1(8'h43, 0);
    @(negedge clk);
    chk("badcs_error", error, 1);
    chk("badcs_done", done, 0);
    chk("badcs_cpu_rst", cpu_rst, 1);
    chk("badcs_busy", busy, 0);
    chk_drained("s2_writes");

    // Illegal counts 0 and 17: error, no writes, stream refused afterwards.
    for (int k = 0; k < 2; k++) begin
      pulse_start();
      send((k == 0) ? 8'h00 : 8'h11, 0);
      @(negedge clk);
      chk("badcnt_error", error, 1);
      chk("badcnt_busy", busy, 0);
      in_valid = 1'b1; in_data = 8'h55;
      repeat (3) begin
        @(negedge clk);
        chk("badcnt_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      tick();
    end
    chk_drained("badcnt_no_writes");

    // Full 16-word load: word k = {2k, 2k+1}, checksum 0x10.
    pulse_start();
    send(8'h10, 0);
    for (int k = 0; k < 16; k++) begin
      expect_write(4'(k), {8'(2*k), 8'(2*k+1)});
      send(8'(2*k), 0);
      send(8'(2*k+1), 0);
    end
    send(8'h10, 0);
    chk_done(5'd16);
    chk_drained("full_writes");

    // Gapped stream with a spurious start mid-load.
    pulse_start();
    expect_write(4'h0, 16'h1234);
    expect_write(4'h1, 16'hABCD);
    send(8'h02, 3); send(8'h12, 3);
    pulse_start();
    chk("midload_start_busy", busy, 1);
    send(8'h34, 3); send(8'hAB, 3); send(8'hCD, 3); send(8'h42, 3);
    chk_done(5'd2);
    chk_drained("gap_writes");

    // Reset after the first word has been written.
    pulse_start();
    expect_write(4'h0, 16'h1234);
    send(8'h02, 0); send(8'h12, 0); send(8'h34, 0);
    @(negedge clk);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("midrst_cpu_rst", cpu_rst, 1);
    chk("midrst_flags", {busy, done, error, in_ready}, 0);
    chk("midrst_words", words_loaded, 0);
    chk("midrst_we_addr_data", {imem_we, imem_addr, imem_wdata}, 0);
    chk_drained("midrst_writes");
    tick();
    pulse_start();
    stream1(8'h42, 0);
    chk_done(5'd2);
    chk_drained("after_rst_writes");

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: the program counter/fetch path reads instruction memory, and this block fills it.
- Accepts a byte stream of the form: word-count header, then hi/lo bytes per instruction, then an XOR checksum byte.
- Assembles 16-bit instructions and writes them sequentially from address 0.
- Holds the CPU in reset until a load completes with a valid checksum, then releases it.

Parameters:
- ADDR_W, 4, instruction-memory address width (depth 2**ADDR_W = 16 words).
- INSTR_W, 16, instruction width; must equal 2*BYTE_W.
- BYTE_W, 8, input stream byte width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- in_valid  in  1  input byte valid.
- in_data  in  BYTE_W  input byte.
- in_ready  out  1  loader can accept a byte; a transfer occurs on in_valid && in_ready.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  INSTR_W  write data, {hi_byte, lo_byte}.
- cpu_rst  out  1  reset to the CPU core (program counter etc.), active-high.
- busy  out  1  load in progress.
- done  out  1  sticky: last load succeeded.
- error  out  1  sticky: last load failed.
- words_loaded  out  ADDR_W+1  words written in the current/last load.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, words_loaded=0, checksum accumulator=0.
- States: IDLE, COUNT, HI, LO, CSUM, DONE, ERROR. All outputs are registered.
- IDLE: on start go to COUNT and set busy=1. cpu_rst stays 1.
- in_ready=1 exactly in COUNT, HI, LO and CSUM. It is 0 elsewhere and in the cycle of the state change out of IDLE, DONE or ERROR.
- COUNT: on transfer, latch N=in_data and set acc=in_data.
  - N==0 or N>16: go to ERROR.
  - Otherwise go to HI, with word index=0 and words_loaded=0.
- HI: on transfer, latch hi byte, acc^=in_data, go to LO.
- LO: on transfer, acc^=in_data. In the next cycle: imem_we=1 for exactly 1 cycle, imem_addr=index, imem_wdata={hi,lo}; index and words_loaded then increment.
  - Go to HI if more words remain, else CSUM.
  - The write is registered, so the stream never stalls for it. Back-to-back bytes are sustainable at 1 byte per cycle.
- CSUM: on transfer, compare in_data with acc.
  - Equal: go to DONE with done=1, busy=0, cpu_rst=0 (next cycle).
  - Not equal: go to ERROR with error=1, busy=0, cpu_rst stays 1.
- ERROR from a bad count sets error=1 and busy=0 the same way.
- DONE/ERROR: in_ready=0, stream bytes ignored. On start: clear done/error, cpu_rst=1, busy=1, go to COUNT.
- start while busy: ignored.
- in_valid low: state holds and accumulates nothing. Gaps of any length are legal.
- Sync rst mid-load: immediate return to reset values. Words already written stay in memory. The CPU remains in reset.
- Index is 0..15. With N=16 the last write is addr 15, and words_loaded reaches 16 (hence the ADDR_W+1 width).
- Checksum = XOR of the count byte and all 2N data bytes. The checksum byte itself is excluded.

Decomposition:
- Shared package (riscv16_pkg): INSTR_W=16, IMEM_ADDR_W=4, IMEM_DEPTH=16, BYTE_W=8, and the loader state enumeration.
- No sub-module is needed. An optional byte_assembler (hi/lo latch plus write-strobe register) is the only natural split.

Test Plan:
- Stream 02,12,34,AB,CD,42 at 1 byte/cycle after start:
  - writes addr0=0x1234, then addr1=0xABCD, each imem_we a single cycle.
  - done=1, cpu_rst=0, words_loaded=2, error=0.
- Same stream with checksum 43:
  - both words written.
  - then error=1, done=0, cpu_rst=1, busy=0.
- Header 00 or 11 (17):
  - ERROR next cycle, no imem_we ever.
  - subsequent bytes are not accepted (in_ready=0).
- 16-word load (count 10, bytes 00..1F, checksum = XOR of 10 and 00..1F = 10):
  - 16 writes, addr 0..15, word k = {2k, 2k+1}.
  - done=1, words_loaded=16.
- Valid 02 stream with in_valid low for 3 cycles between every byte: same writes and result as the first scenario. start pulsed mid-load is ignored.
- rst asserted after the first word is written:
  - next cycle all outputs at reset values with cpu_rst=1.
  - a new start plus the first-scenario stream then completes normally.
